// File: rtl/control_pkg.sv
// control_pkg: states, opcodes and datapath select encodings for the multi-cycle MIPS control unit
package control_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_MEM,
        S_EXEC_R, S_EXEC_I, S_WB_R, S_WB_I, S_BRANCH, S_JUMP, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_FUNCT = 3'b001;
    localparam logic [2:0] ALU_SLT   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SUB   = 3'b101;

    localparam logic [1:0] SRCB_RT   = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BR   = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic [2:0] imm_alu(input logic [5:0] op);
        return op == OP_ANDI ? ALU_AND : op == OP_ORI ? ALU_OR : op == OP_SLTI ? ALU_SLT : ALU_ADD;
    endfunction
endpackage

// File: rtl/control_multiciclo_if.sv
// control_multiciclo_if: run/opcode/memory handshake inputs and datapath control outputs of the controller
interface control_multiciclo_if #(parameter int ALUOP_W = 3, parameter int CNT_W = 32);
    logic               run;
    logic [5:0]         op;
    logic               mem_ready;
    logic               mem_req;
    logic               mem_we;
    logic               i_or_d;
    logic               ir_write;
    logic               pc_write;
    logic               pc_write_cond;
    logic [1:0]         pc_source;
    logic               reg_dst;
    logic               mem_to_reg;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               instr_done;
    logic               illegal_op;
    logic               bus_error;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  run, op, mem_ready,
        output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               instr_done, illegal_op, bus_error, retired
    );

    modport slave (
        output run, op, mem_ready,
        input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_source,
               reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
               instr_done, illegal_op, bus_error, retired
    );
endinterface

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts consecutive memory wait cycles and flags when the limit is reached (0 disables)
module mem_watchdog #(parameter int MEM_TIMEOUT = 15) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,
    input  logic clear,
    output logic expired
);
    localparam int W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) cnt <= '0;
        else if (waiting && !expired) cnt <= cnt + W'(1);
    end

    assign expired = MEM_TIMEOUT != 0 && cnt == W'(MEM_TIMEOUT);
endmodule

// File: rtl/control_multiciclo.sv
// control_multiciclo: multi-cycle MIPS control FSM with memory watchdog, traps, run/halt and retire counter
module control_multiciclo
    import control_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32,
    parameter bit ENABLE_J    = 1
) (
    input logic clk,
    input logic rst_n,
    control_multiciclo_if.master bus
);
    state_t     state, state_next, after_instr;
    logic [2:0] alu_i;
    logic       waiting, expired;

    assign waiting     = (state == S_FETCH || state == S_MEM_RD || state == S_MEM_WR) && !bus.mem_ready;
    assign after_instr = bus.run ? S_FETCH : S_IDLE;
    assign bus.instr_done = state == S_WB_MEM || state == S_WB_R || state == S_WB_I ||
                            state == S_BRANCH || state == S_JUMP || (state == S_MEM_WR && bus.mem_ready);

    mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
        .clk(clk), .rst_n(rst_n), .waiting(waiting), .clear(state_next != state), .expired(expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            alu_i          <= ALU_ADD;
            bus.illegal_op <= 1'b0;
            bus.bus_error  <= 1'b0;
            bus.retired    <= '0;
        end else begin
            state <= state_next;
            if (state == S_DECODE) alu_i <= imm_alu(bus.op);
            if (state == S_DECODE && state_next == S_TRAP) bus.illegal_op <= 1'b1;
            if (waiting && expired) bus.bus_error <= 1'b1;
            if (bus.instr_done) bus.retired <= bus.retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     state_next = bus.run ? S_FETCH : S_IDLE;
            S_FETCH:    state_next = bus.mem_ready ? S_DECODE : expired ? S_TRAP : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:                          state_next = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_EXEC_I;
                    OP_LW, OP_SW:                      state_next = S_MEM_ADDR;
                    OP_BEQ:                            state_next = S_BRANCH;
                    OP_J:                              state_next = ENABLE_J ? S_JUMP : S_TRAP;
                    default:                           state_next = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_next = bus.op == OP_SW ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_next = bus.mem_ready ? S_WB_MEM : expired ? S_TRAP : S_MEM_RD;
            S_MEM_WR:   state_next = bus.mem_ready ? after_instr : expired ? S_TRAP : S_MEM_WR;
            S_EXEC_R:   state_next = S_WB_R;
            S_EXEC_I:   state_next = S_WB_I;
            S_WB_MEM, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state_next = after_instr;
            default:    state_next = state;
        endcase
    end

    // Moore decode; only the fetch-time IR/PC loads wait on the memory handshake
    always_comb begin
        bus.mem_req       = 1'b0;
        bus.mem_we        = 1'b0;
        bus.i_or_d        = 1'b0;
        bus.ir_write      = 1'b0;
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.pc_source     = PCSRC_ALU;
        bus.reg_dst       = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_src_b     = SRCB_RT;
        bus.alu_op        = ALUOP_W'(ALU_ADD);
        case (state)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.ir_write  = bus.mem_ready;
                bus.pc_write  = bus.mem_ready;
                bus.alu_src_b = SRCB_FOUR;
            end
            S_DECODE:   bus.alu_src_b = SRCB_BR;
            S_MEM_ADDR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.i_or_d  = 1'b1;
            end
            S_MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.i_or_d  = 1'b1;
            end
            S_WB_MEM: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_EXEC_R: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = ALUOP_W'(ALU_FUNCT);
            end
            S_WB_R: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = SRCB_IMM;
                bus.alu_op    = ALUOP_W'(alu_i);
            end
            S_WB_I:     bus.reg_write = 1'b1;
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = ALUOP_W'(ALU_SUB);
                bus.pc_write_cond = 1'b1;
                bus.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                bus.pc_write  = 1'b1;
                bus.pc_source = PCSRC_JUMP;
            end
            default: ;
        endcase
    end
endmodule
